// File: rtl/pulsegen_mc.sv
// Multi-channel repeating pulse sequencer: one shared frame counter, NCH compare windows.
// Optional build macro PULSEGEN_MC_POL_EN adds per-channel output inversion (pol).
module pulsegen_mc #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int RW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic              abort,
  input  logic [CW-1:0]     period,
  input  logic [RW-1:0]     repeats,
  input  logic [NCH*CW-1:0] t_rise,
  input  logic [NCH*CW-1:0] t_fall,
`ifdef PULSEGEN_MC_POL_EN
  input  logic [NCH-1:0]    pol,
`endif
  output logic [NCH-1:0]    q,
  output logic [NCH-1:0]    qbar,
  output logic              busy,
  output logic              done,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Handshake: trig is a level sampled at each edge and only accepted in IDLE
  // (and only when abort is low); done pulses for the single cycle after the last RUN cycle.

  logic [0:0]        state;
  logic [CW-1:0]     counter;
  logic [RW-1:0]     frame_idx;
  logic [CW-1:0]     period_sh;
  logic [RW-1:0]     repeats_sh;
  logic [NCH*CW-1:0] rise_sh;
  logic [NCH*CW-1:0] fall_sh;
  logic [NCH-1:0]    win;
`ifdef PULSEGEN_MC_POL_EN
  logic [NCH-1:0]    pol_sh;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      frame_idx  <= '0;
      done       <= 1'b0;
      period_sh  <= CW'(1);
      repeats_sh <= '0;
      rise_sh    <= '0;
      fall_sh    <= '0;
`ifdef PULSEGEN_MC_POL_EN
      pol_sh     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        if (abort) begin
          state     <= IDLE;
          counter   <= '0;
          frame_idx <= '0;
        end else if (counter == period_sh) begin
          if (frame_idx == repeats_sh) begin
            state     <= IDLE;
            counter   <= '0;
            frame_idx <= '0;
            done      <= 1'b1;
          end else begin
            frame_idx <= frame_idx + 1'b1;
            counter   <= CW'(1);
          end
        end else begin
          counter <= counter + 1'b1;
        end
      end else if (trig && !abort) begin
        // A zero period is folded to 1 at capture so the frame-end compare stays simple.
        period_sh  <= (period == '0) ? CW'(1) : period;
        repeats_sh <= repeats;
        rise_sh    <= t_rise;
        fall_sh    <= t_fall;
`ifdef PULSEGEN_MC_POL_EN
        pol_sh     <= pol;
`endif
        counter    <= CW'(1);
        frame_idx  <= '0;
        state      <= RUN;
      end
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NCH; i++) begin
      win[i] = (state == RUN) &&
               (counter > rise_sh[i*CW +: CW]) &&
               !(counter > fall_sh[i*CW +: CW]);
    end
  end

`ifdef PULSEGEN_MC_POL_EN
  assign q = (state == RUN) ? (win ^ pol_sh) : pol_sh;
`else
  assign q = win;
`endif

  assign qbar      = ~q;
  assign busy      = (state == RUN);
  assign dbg_state = state;

endmodule
